// File: rtl/neuron_2_1.sv
// Layer-2 neuron 1: streams activations against a 1-cycle-latency weight memory,
// accumulates one vector of products, adds bias and emits a saturated ReLU result.
module neuron_2_1 #(
  parameter int unsigned numWeight    = 30,
  parameter int unsigned addressWidth = $clog2(numWeight),
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned FRAC_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    bias,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_valid
);

  localparam int unsigned MUL_W = 2 * dataWidth;
  localparam int unsigned ACC_W = 2 * dataWidth + addressWidth + 1;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

  logic [addressWidth-1:0]    idx;
  logic [dataWidth-1:0]       in_d;
  logic                       v1, last1, v2, last2, sv;
  logic signed [MUL_W-1:0]    mul_r;
  logic signed [ACC_W-1:0]    acc, sum_r;
  logic signed [ACC_W-1:0]    mul_ext_c, bias_ext_c, y_c;
  logic [dataWidth-1:0]       out_c;

  assign w_ren  = in_valid;
  assign w_radd = idx;

  // Input index and capture stage; the weight memory registers its read alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      in_d  <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v1    <= in_valid;
      last1 <= in_valid && (idx == LAST_IDX);
      if (in_valid) begin
        in_d <= in_data;
        idx  <= (idx == LAST_IDX) ? '0 : idx + addressWidth'(1);
      end
    end
  end

  // Multiply stage: full-width signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_r <= '0;
      v2    <= 1'b0;
      last2 <= 1'b0;
    end else begin
      v2    <= v1;
      last2 <= last1;
      if (v1) mul_r <= $signed(in_d) * $signed(w_rdata);
    end
  end

  assign mul_ext_c  = ACC_W'(mul_r);
  assign bias_ext_c = ACC_W'($signed(bias)) <<< FRAC_BITS;

  // Accumulate; the last product closes the vector and clears acc in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sum_r <= '0;
      sv    <= 1'b0;
    end else begin
      sv <= 1'b0;
      if (v2) begin
        if (last2) begin
          sum_r <= acc + mul_ext_c + bias_ext_c;
          acc   <= '0;
          sv    <= 1'b1;
        end else begin
          acc <= acc + mul_ext_c;
        end
      end
    end
  end

  // Drop fraction (floor), clamp negatives to zero and large values to max positive.
  always_comb begin
    y_c   = sum_r >>> FRAC_BITS;
    out_c = y_c[dataWidth-1:0];
    if (y_c[ACC_W-1]) begin
      out_c = '0;
    end else if (|y_c[ACC_W-2:dataWidth-1]) begin
      out_c = {1'b0, {(dataWidth-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sv;
      if (sv) out_data <= out_c;
    end
  end

endmodule

// File: tb/tb_neuron_2_1.sv
// Scoreboard bench for neuron_2_1: behavioural dot-product model feeds an expectation
// queue, a negedge monitor pops and checks every out_valid pulse (value and latency).
module tb_neuron_2_1;

  localparam int NW = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] bias = '0;
  logic        w_ren;
  logic [4:0]  w_radd;
  logic [15:0] w_rdata = '0;
  logic [15:0] out_data;
  logic        out_valid;

  neuron_2_1 dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .bias(bias),
    .w_ren(w_ren), .w_radd(w_radd), .w_rdata(w_rdata),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wmem[NW];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          idx_m = 0;
  longint      acc_m = 0;
  int          last_pulse = -1;
  int          pulse_gap = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: registered read, one cycle latency.
  always @(posedge clk) if (w_ren) w_rdata <= wmem[w_radd];

  function automatic logic [15:0] relu_sat(input longint s);
    longint y;
    y = s >>> 8;
    if (y < 0) return 16'd0;
    if (y > 32767) return 16'd32767;
    return 16'(y);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (last_pulse >= 0) pulse_gap = cyc - last_pulse;
      last_pulse = cyc;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", longint'(out_data), longint'(e.val));
        check("out_latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check("w_ren", longint'(w_ren), 1);
    check("w_radd", longint'(w_radd), idx_m);
    acc_m += longint'($signed(d)) * longint'($signed(wmem[idx_m]));
    if (idx_m == NW - 1) begin
      exp_t e;
      e.val = relu_sat(acc_m + longint'($signed(bias)) * 256);
      e.cyc = cyc + 4;
      sb.push_back(e);
      acc_m = 0;
      idx_m = 0;
    end else begin
      idx_m++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic vec_const(input logic [15:0] d, input int gapmax);
    for (int i = 0; i < NW; i++) begin
      if (gapmax > 0) idle($urandom_range(gapmax));
      issue(d);
    end
  endtask

  task automatic vec_rand(input int gapmax);
    for (int i = 0; i < NW; i++) begin
      if (gapmax > 0) idle($urandom_range(gapmax));
      issue(16'($urandom));
    end
  endtask

  task automatic set_weights(input logic [15:0] w);
    for (int i = 0; i < NW; i++) wmem[i] = w;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    idle(3);
  endtask

  initial begin
    set_weights(16'd0);
    repeat (3) @(negedge clk);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_w_radd", longint'(w_radd), 0);
    check("reset_w_ren", longint'(w_ren), 0);
    rst_n = 1'b1;
    idle(2);

    // 1.0 * 1.0 over 30 inputs
    set_weights(16'd256); bias = 16'd0;
    vec_const(16'd256, 0); drain();
    // all negative -> ReLU
    set_weights(16'hFF00);
    vec_const(16'd256, 0); drain();
    // saturation
    set_weights(16'd256);
    vec_const(16'd32512, 0); drain();
    // bias only, positive then negative
    set_weights(16'd0); bias = 16'd640;
    vec_rand(0); drain();
    bias = 16'hFD80;
    vec_rand(0); drain();

    // back-to-back vectors, then the same with random gaps
    set_weights(16'd256); bias = 16'd0;
    last_pulse = -1;
    vec_const(16'd256, 0);
    vec_const(16'd128, 0);
    drain();
    check("b2b_pulse_spacing", pulse_gap, NW);
    vec_const(16'd256, 3);
    vec_const(16'd128, 3);
    drain();

    // reset mid-vector discards the partial sum
    for (int i = 0; i < 10; i++) issue(16'd256);
    rst_n = 1'b0;
    idx_m = 0; acc_m = 0;
    idle(2);
    check("midreset_out_valid", longint'(out_valid), 0);
    check("midreset_out_data", longint'(out_data), 0);
    check("midreset_w_radd", longint'(w_radd), 0);
    rst_n = 1'b1;
    idle(2);
    vec_const(16'd256, 0); drain();

    // random weights, activations, bias and gaps
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NW; i++) wmem[i] = 16'($urandom);
      bias = 16'($urandom);
      vec_rand(v % 3);
      drain();
    end
    // random back-to-back run with fixed random weights
    for (int i = 0; i < NW; i++) wmem[i] = 16'($urandom_range(1024)) - 16'd512;
    bias = 16'($urandom_range(4096));
    for (int v = 0; v < 4; v++) vec_rand(0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_2_1.md
Name: neuron_2_1

Overview:
Layer-2 neuron 1 compute stage. It consumes the 30-entry weight memory for this neuron, which has a registered read with 1-cycle latency. For each incoming activation it issues a weight read and multiplies the activation by the returned weight. Products are summed over one input vector, the bias is added, and a saturated ReLU result is produced with a one-cycle valid pulse toward the layer-2 output collector.

Parameters:
numWeight, 30, inputs per vector (equals weight memory depth)
addressWidth, $clog2(numWeight), weight memory address width
dataWidth, 16, signed two's-complement width of activations, weights, bias and output
FRAC_BITS, 8, fractional bits of the fixed-point format (shared by activations, weights, bias and output)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active low
in_data  input  dataWidth  signed activation
in_valid  input  1  in_data valid this cycle; no backpressure, accepted unconditionally
bias  input  dataWidth  signed bias, held static during operation
w_ren  output  1  weight memory read enable (combinational = in_valid)
w_radd  output  addressWidth  weight read address (= input index counter)
w_rdata  input  dataWidth  weight returned one cycle after w_ren
out_data  output  dataWidth  ReLU, saturated neuron output
out_valid  output  1  one-cycle pulse, out_data valid

Behaviour:
- Reset (async, rst_n=0): idx=0, acc=0, all pipeline valid/last flags=0, out_data=0, out_valid=0. Reset mid-vector discards the partial sum. No out_valid is produced for a partial vector.
- Input index idx: increments on each in_valid. Wraps from numWeight-1 to 0. w_radd=idx, w_ren=in_valid.
- Pipeline, with t = cycle in_valid is high:
  - Edge end of t: in_d<=in_data, v1<=1, last1<=(idx==numWeight-1). The memory registers the weight.
  - Edge end of t+1: mul_r<=signed(in_d)*signed(w_rdata), a full 2*dataWidth product. v2<=v1, last2<=last1.
  - Edge end of t+2, when v2:
    - Not last2: acc<=acc+mul_r.
    - last2: sum_r<=acc+mul_r+(sext(bias)<<FRAC_BITS), acc<=0, sv<=1. Otherwise sv<=0.
  - Edge end of t+3: out_data<=f(sum_r), out_valid<=sv.
- Latency: out_valid is high in cycle t_last+4, where t_last is the cycle of the vector's last in_valid.
- acc and sum_r width: 2*dataWidth+addressWidth+1 bits, signed, no overflow possible.
- f(x):
  - y = x >>> FRAC_BITS, arithmetic shift (floor).
  - If y<0, out=0 (ReLU).
  - Else if y>2^(dataWidth-1)-1, out=2^(dataWidth-1)-1 (saturate).
  - Else out=y[dataWidth-1:0].
- Gaps: in_valid may drop for any number of cycles mid-vector. Only valid cycles advance idx and the pipeline.
- Back-to-back vectors: the first input of the next vector may arrive the cycle after the last input of the previous one. The last product clears acc in the same edge, so no cross-vector contamination.
- out_data holds its value between pulses. out_valid is never high two consecutive cycles unless back-to-back single-cycle spacing allows it (numWeight=1 only).

Test Plan:
1. Memory model holds all weights 256 (1.0), bias=0, 30 contiguous inputs of 256 -> single out_valid at t_last+4 with out_data=7680; w_radd sequence 0..29.
2. All weights -256, inputs 256, bias=0 -> out_data=0 (ReLU).
3. Weights 256, inputs 32512 (127.0), bias=0 -> out_data=32767 (saturation).
4. Weights 0, bias=640 (2.5), any inputs -> out_data=640. Same with bias=-640 -> out_data=0.
5. Two vectors back-to-back: vector A as in scenario 1, vector B with inputs 128 -> outputs 7680 then 3840, pulses 30 cycles apart. Repeat with random in_valid gaps -> same values.
6. Assert rst_n low after 10 inputs, release, send a full vector as in scenario 1 -> no pulse from the partial vector; one pulse with 7680; w_radd restarts at 0.
